// File: rtl/lpgbt_downlink_frame_builder_pkg.sv
// lpgbt_dl_pkg: shared widths, slow-control idle code, serializer states and PRBS7 stepping helper
package lpgbt_dl_pkg;
  localparam int DL_USER_W = 32;
  localparam int DL_SC_W = 2;
  localparam logic [1:0] SC_IDLE = 2'b11;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
  typedef enum logic {S_IDLE, S_SHIFT} sc_state_t;
  function automatic logic [38:0] prbs7_step32(input logic [6:0] s);
    logic [6:0] r;
    logic [31:0] w;
    r = s;
    w = '0;
    for (int i = 31; i >= 0; i--) begin
      w[i] = ^(r & PRBS7_TAPS);
      r = {r[5:0], w[i]};
    end
    return {w, r};
  endfunction
endpackage

// File: rtl/lpgbt_downlink_frame_builder_if.sv
// lpgbt_downlink_frame_builder_if: host-side user/IC/EC handshakes plus encoder-side frame fields and status; master=host, slave=builder
interface lpgbt_downlink_frame_builder_if #(parameter int FIFO_DEPTH = 16);
  import lpgbt_dl_pkg::*;
  logic downlinkRdy_i;
  logic [DL_USER_W-1:0] usrData_i;
  logic usrValid_i;
  logic usrReady_o;
  logic [7:0] icByte_i;
  logic icValid_i;
  logic icReady_o;
  logic [7:0] ecByte_i;
  logic ecValid_i;
  logic ecReady_o;
  logic prbsEnable_i;
  logic [DL_USER_W-1:0] downlinkUserData_o;
  logic [DL_SC_W-1:0] downlinkIcData_o;
  logic [DL_SC_W-1:0] downlinkEcData_o;
  logic [$clog2(FIFO_DEPTH):0] fifoLevel_o;
  logic [15:0] idleCnt_o;
  logic [31:0] frameCnt_o;
  modport master (
    output downlinkRdy_i, usrData_i, usrValid_i, icByte_i, icValid_i, ecByte_i, ecValid_i, prbsEnable_i,
    input usrReady_o, icReady_o, ecReady_o, downlinkUserData_o, downlinkIcData_o, downlinkEcData_o,
    fifoLevel_o, idleCnt_o, frameCnt_o
  );
  modport slave (
    input downlinkRdy_i, usrData_i, usrValid_i, icByte_i, icValid_i, ecByte_i, ecValid_i, prbsEnable_i,
    output usrReady_o, icReady_o, ecReady_o, downlinkUserData_o, downlinkIcData_o, downlinkEcData_o,
    fifoLevel_o, idleCnt_o, frameCnt_o
  );
endinterface

// File: rtl/lpgbt_downlink_frame_builder_sc_serializer.sv
// lpgbt_dl_sc_serializer: byte in (byte_i/valid_i/ready_o), 2-bit pair per ready frame out (data_o), LSB pair first, gapless back-to-back
module lpgbt_dl_sc_serializer
  import lpgbt_dl_pkg::*;
(
  input  logic clk40_i,
  input  logic downlinkRst_i,
  input  logic downlinkRdy_i,
  input  logic [7:0] byte_i,
  input  logic valid_i,
  output logic ready_o,
  output logic [DL_SC_W-1:0] data_o
);
  sc_state_t state;
  logic [7:0] sr;
  logic [1:0] cnt;
  logic take;
  assign ready_o = !downlinkRst_i && downlinkRdy_i && (state == S_IDLE || cnt == 2'd3);
  assign take = ready_o && valid_i;
  always_ff @(posedge clk40_i) begin
    if (downlinkRst_i) begin
      state <= S_IDLE;
      sr <= '0;
      cnt <= '0;
      data_o <= SC_IDLE;
    end else if (!downlinkRdy_i) begin
      data_o <= SC_IDLE;
    end else begin
      data_o <= state == S_SHIFT ? sr[{cnt, 1'b1} -: 2] : SC_IDLE;
      cnt <= (take || state == S_IDLE) ? 2'd0 : cnt + 2'd1;
      if (take) sr <= byte_i;
      state <= take ? S_SHIFT : (state == S_SHIFT && cnt != 2'd3) ? S_SHIFT : S_IDLE;
    end
  end
endmodule

// File: rtl/lpgbt_downlink_frame_builder.sv
// lpgbt_downlink_frame_builder: clk40_i/downlinkRst_i + dl (slave) -> per-frame user/IC/EC fields, FIFO level, idle/frame counters; optional PRBS7 user field under LPGBT_DL_PRBS_EN
module lpgbt_downlink_frame_builder
  import lpgbt_dl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter logic [DL_USER_W-1:0] IDLE_WORD = 32'h0000_0000
) (
  input logic clk40_i,
  input logic downlinkRst_i,
  lpgbt_downlink_frame_builder_if.slave dl
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DL_USER_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic push, pop, empty, prbs_mode;
  logic [DL_USER_W-1:0] prbs_word;
  assign empty = level == '0;
  assign dl.usrReady_o = !downlinkRst_i && level < (AW+1)'(FIFO_DEPTH);
  assign push = dl.usrValid_i && dl.usrReady_o;
  assign pop = dl.downlinkRdy_i && !empty && !prbs_mode;
  assign dl.fifoLevel_o = level;
`ifdef LPGBT_DL_PRBS_EN
  logic [6:0] prbs_st;
  logic [38:0] prbs_nx;
  assign prbs_mode = dl.prbsEnable_i;
  assign prbs_nx = prbs7_step32(prbs_st);
  assign prbs_word = prbs_nx[38:7];
  always_ff @(posedge clk40_i)
    prbs_st <= (downlinkRst_i || !prbs_mode) ? PRBS7_SEED : dl.downlinkRdy_i ? prbs_nx[6:0] : prbs_st;
`else
  logic unused_prbs;
  assign unused_prbs = dl.prbsEnable_i;
  assign prbs_mode = 1'b0;
  assign prbs_word = IDLE_WORD;
`endif
  always_ff @(posedge clk40_i)
    if (push) mem[wr_ptr] <= dl.usrData_i;
  always_ff @(posedge clk40_i) begin
    if (downlinkRst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      dl.downlinkUserData_o <= IDLE_WORD;
      dl.idleCnt_o <= '0;
      dl.frameCnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      dl.downlinkUserData_o <= !dl.downlinkRdy_i ? IDLE_WORD : prbs_mode ? prbs_word : pop ? mem[rd_ptr] : IDLE_WORD;
      if (dl.downlinkRdy_i) dl.frameCnt_o <= dl.frameCnt_o + 32'd1;
      if (dl.downlinkRdy_i && empty && !prbs_mode && dl.idleCnt_o != 16'hFFFF) dl.idleCnt_o <= dl.idleCnt_o + 16'd1;
    end
  end
  lpgbt_dl_sc_serializer u_ic (
    .clk40_i(clk40_i), .downlinkRst_i(downlinkRst_i), .downlinkRdy_i(dl.downlinkRdy_i),
    .byte_i(dl.icByte_i), .valid_i(dl.icValid_i), .ready_o(dl.icReady_o), .data_o(dl.downlinkIcData_o)
  );
  lpgbt_dl_sc_serializer u_ec (
    .clk40_i(clk40_i), .downlinkRst_i(downlinkRst_i), .downlinkRdy_i(dl.downlinkRdy_i),
    .byte_i(dl.ecByte_i), .valid_i(dl.ecValid_i), .ready_o(dl.ecReady_o), .data_o(dl.downlinkEcData_o)
  );
endmodule

// File: tb/tb_lpgbt_downlink_frame_builder.sv
// tb_lpgbt_downlink_frame_builder: directed and randomized checks of the frame builder against a queue-based reference model
module tb_lpgbt_downlink_frame_builder;
  localparam int DEPTH = 16;
  localparam logic [31:0] IDLE = 32'h0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  logic [1:0] icq[$];
  logic [1:0] ecq[$];
  bit hist[$];
  logic [31:0] m_data = IDLE;
  logic [31:0] m_frame = '0;
  logic [15:0] m_idle = '0;
  logic [1:0] m_ic = 2'b11;
  logic [1:0] m_ec = 2'b11;

  lpgbt_downlink_frame_builder_if #(.FIFO_DEPTH(DEPTH)) dl();
  lpgbt_downlink_frame_builder #(.FIFO_DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
    .clk40_i(clk), .downlinkRst_i(rst), .dl(dl)
  );
  always #5 clk = ~clk;

  function automatic bit m_usr_ready();
    return !rst && q.size() < DEPTH;
  endfunction
  function automatic bit m_sc_ready(int n);
    return !rst && dl.downlinkRdy_i && n <= 1;
  endfunction
  function automatic void reseed();
    hist.delete();
    repeat (7) hist.push_back(1'b1);
  endfunction
  // PRBS7 as the recurrence x[n] = x[n-7] ^ x[n-6], hist[0] oldest
  function automatic logic [31:0] prbs_next();
    logic [31:0] w;
    for (int i = 31; i >= 0; i--) begin
      w[i] = hist[0] ^ hist[1];
      hist.push_back(w[i]);
      void'(hist.pop_front());
    end
    return w;
  endfunction

  task automatic model_edge();
    bit push, icp, ecp, pm;
    push = dl.usrValid_i && m_usr_ready();
    icp = dl.icValid_i && m_sc_ready(icq.size());
    ecp = dl.ecValid_i && m_sc_ready(ecq.size());
`ifdef LPGBT_DL_PRBS_EN
    pm = dl.prbsEnable_i;
`else
    pm = 1'b0;
`endif
    if (rst) begin
      q.delete(); icq.delete(); ecq.delete();
      m_data = IDLE; m_ic = 2'b11; m_ec = 2'b11; m_idle = '0; m_frame = '0;
      reseed();
      return;
    end
    if (!dl.downlinkRdy_i) begin
      m_data = IDLE; m_ic = 2'b11; m_ec = 2'b11;
    end else begin
      m_frame = m_frame + 1;
      if (pm) m_data = prbs_next();
      else if (q.size() > 0) m_data = q.pop_front();
      else begin
        m_data = IDLE;
        if (m_idle != 16'hFFFF) m_idle = m_idle + 1;
      end
      m_ic = 2'b11;
      m_ec = 2'b11;
      if (icq.size() > 0) m_ic = icq.pop_front();
      if (ecq.size() > 0) m_ec = ecq.pop_front();
      for (int i = 0; i < 4; i++) begin
        if (icp) icq.push_back(dl.icByte_i[2*i +: 2]);
        if (ecp) ecq.push_back(dl.ecByte_i[2*i +: 2]);
      end
    end
    if (push) q.push_back(dl.usrData_i);
    if (!pm) reseed();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dl.downlinkRdy_i = 1'b1;
    tick(); tick();
    checks++;
    if ({dl.usrReady_o, dl.icReady_o, dl.ecReady_o} !== 3'b000) begin
      failures++; $display("FAIL reset_ready got %b exp 000", {dl.usrReady_o, dl.icReady_o, dl.ecReady_o});
    end
    checks++;
    if ({dl.downlinkUserData_o, dl.downlinkIcData_o, dl.downlinkEcData_o} !== {IDLE, 4'b1111}) begin
      failures++; $display("FAIL reset_fields got %h/%b/%b", dl.downlinkUserData_o, dl.downlinkIcData_o, dl.downlinkEcData_o);
    end
    checks++;
    if ({dl.fifoLevel_o, dl.idleCnt_o, dl.frameCnt_o} !== '0) begin
      failures++; $display("FAIL reset_counts got lvl=%0d idle=%0d frame=%0d", dl.fifoLevel_o, dl.idleCnt_o, dl.frameCnt_o);
    end
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (dl.idleCnt_o !== 16'd10 || dl.frameCnt_o !== 32'd10) begin
      failures++; $display("FAIL idle_frames got idle=%0d frame=%0d exp 10/10", dl.idleCnt_o, dl.frameCnt_o);
    end
    checks++;
    if ({dl.downlinkUserData_o, dl.downlinkIcData_o, dl.downlinkEcData_o} !== {32'h0, 4'b1111}) begin
      failures++; $display("FAIL idle_fields got %h/%b/%b", dl.downlinkUserData_o, dl.downlinkIcData_o, dl.downlinkEcData_o);
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp [5];
    exp = '{IDLE, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, IDLE};
    dl.downlinkRdy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dl.usrValid_i = i < 3;
      dl.usrData_i = 32'hA5A5_0001 + i;
      tick();
      checks++;
      if (dl.downlinkUserData_o !== exp[i]) begin
        failures++; $display("FAIL latency[%0d] got %h exp %h", i, dl.downlinkUserData_o, exp[i]);
      end
    end
    dl.usrValid_i = 1'b0;
  endtask

  task automatic test_fill();
    bit acc;
    dl.downlinkRdy_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dl.usrValid_i = 1'b1;
      dl.usrData_i = 32'hB000_0000 + i;
      tick();
    end
    checks++;
    if (dl.fifoLevel_o !== 5'd16 || dl.usrReady_o !== 1'b0) begin
      failures++; $display("FAIL fill_full got lvl=%0d rdy=%b exp 16/0", dl.fifoLevel_o, dl.usrReady_o);
    end
    dl.usrData_i = 32'hB000_0010;
    tick();
    checks++;
    if (dl.fifoLevel_o !== 5'd16 || dl.frameCnt_o !== m_frame) begin
      failures++; $display("FAIL fill_stall got lvl=%0d frame=%0d exp 16/%0d", dl.fifoLevel_o, dl.frameCnt_o, m_frame);
    end
    dl.downlinkRdy_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      acc = dl.usrValid_i && m_usr_ready();
      tick();
      if (acc) dl.usrValid_i = 1'b0;
      checks++;
      if (dl.downlinkUserData_o !== 32'hB000_0000 + i) begin
        failures++; $display("FAIL drain[%0d] got %h exp %h", i, dl.downlinkUserData_o, 32'hB000_0000 + i);
      end
    end
    checks++;
    if (dl.fifoLevel_o !== 5'd0) begin
      failures++; $display("FAIL drain_level got %0d exp 0", dl.fifoLevel_o);
    end
  endtask

  task automatic test_ic();
    logic [1:0] e1 [5];
    logic [1:0] e2 [9];
    bit acc;
    e1 = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11};
    e2 = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    dl.downlinkRdy_i = 1'b1;
    #1;
    checks++;
    if (dl.icReady_o !== 1'b1) begin
      failures++; $display("FAIL ic_idle_ready got %b exp 1", dl.icReady_o);
    end
    dl.icValid_i = 1'b1;
    dl.icByte_i = 8'hB4;
    tick();
    dl.icValid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dl.downlinkIcData_o !== e1[i]) begin
        failures++; $display("FAIL ic_single[%0d] got %b exp %b", i, dl.downlinkIcData_o, e1[i]);
      end
    end
    dl.icValid_i = 1'b1;
    dl.icByte_i = 8'hB4;
    tick();
    dl.icByte_i = 8'h0F;
    for (int i = 0; i < 9; i++) begin
      acc = dl.icValid_i && m_sc_ready(icq.size());
      tick();
      if (acc) dl.icValid_i = 1'b0;
      checks++;
      if (dl.downlinkIcData_o !== e2[i] || dl.downlinkEcData_o !== 2'b11) begin
        failures++; $display("FAIL ic_b2b[%0d] got %b/%b exp %b/11", i, dl.downlinkIcData_o, dl.downlinkEcData_o, e2[i]);
      end
    end
    dl.icValid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    dl.downlinkRdy_i = 1'b1;
    dl.icValid_i = 1'b1; dl.icByte_i = 8'hC3;
    dl.ecValid_i = 1'b1; dl.ecByte_i = 8'h5A;
    tick();
    dl.icValid_i = 1'b0; dl.ecValid_i = 1'b0;
    tick();
    dl.downlinkRdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dl.usrValid_i = 1'b1; dl.usrData_i = 32'hC000_0000 + i;
      tick();
    end
    dl.usrValid_i = 1'b0;
    checks++;
    if (dl.fifoLevel_o !== 5'd5) begin
      failures++; $display("FAIL mid_level got %0d exp 5", dl.fifoLevel_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({dl.downlinkUserData_o, dl.downlinkIcData_o, dl.downlinkEcData_o, dl.fifoLevel_o, dl.idleCnt_o, dl.frameCnt_o}
        !== {IDLE, 4'b1111, 5'd0, 16'd0, 32'd0}) begin
      failures++; $display("FAIL mid_reset got %h/%b/%b lvl=%0d idle=%0d frame=%0d", dl.downlinkUserData_o,
        dl.downlinkIcData_o, dl.downlinkEcData_o, dl.fifoLevel_o, dl.idleCnt_o, dl.frameCnt_o);
    end
    checks++;
    if ({dl.usrReady_o, dl.icReady_o, dl.ecReady_o} !== 3'b000) begin
      failures++; $display("FAIL mid_reset_ready got %b exp 000", {dl.usrReady_o, dl.icReady_o, dl.ecReady_o});
    end
    rst = 1'b0;
    dl.downlinkRdy_i = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (dl.downlinkIcData_o !== 2'b11 || dl.downlinkEcData_o !== 2'b11 || dl.downlinkUserData_o !== IDLE) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL mid_dropped got %0d non-idle frames exp 0", bad);
    end
  endtask

  task automatic test_prbs();
    logic [15:0] idle0;
    dl.downlinkRdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dl.usrValid_i = 1'b1; dl.usrData_i = 32'hD000_0000 + i;
      tick();
    end
    dl.usrValid_i = 1'b0;
    idle0 = m_idle;
    dl.prbsEnable_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      dl.downlinkRdy_i = $urandom_range(0, 3) != 0;
      tick();
      checks++;
      if (dl.downlinkUserData_o !== m_data || dl.fifoLevel_o !== 5'(q.size())) begin
        failures++; $display("FAIL prbs[%0d] got %h lvl=%0d exp %h lvl=%0d", i, dl.downlinkUserData_o, dl.fifoLevel_o, m_data, q.size());
      end
`ifdef LPGBT_DL_PRBS_EN
      checks++;
      if (dl.fifoLevel_o !== 5'd3 || dl.idleCnt_o !== idle0) begin
        failures++; $display("FAIL prbs_hold[%0d] got lvl=%0d idle=%0d exp 3/%0d", i, dl.fifoLevel_o, dl.idleCnt_o, idle0);
      end
`endif
    end
    dl.prbsEnable_i = 1'b0;
    dl.downlinkRdy_i = 1'b1;
    repeat (5) tick();
    checks++;
    if (dl.fifoLevel_o !== 5'd0 || dl.idleCnt_o !== m_idle) begin
      failures++; $display("FAIL prbs_exit got lvl=%0d idle=%0d exp 0/%0d", dl.fifoLevel_o, dl.idleCnt_o, m_idle);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 99) == 0;
      dl.downlinkRdy_i = $urandom_range(0, 3) != 0;
      dl.usrValid_i = $urandom_range(0, 1);
      dl.usrData_i = $urandom;
      dl.icValid_i = $urandom_range(0, 1);
      dl.icByte_i = 8'($urandom);
      dl.ecValid_i = $urandom_range(0, 1);
      dl.ecByte_i = 8'($urandom);
      if ($urandom_range(0, 49) == 0) dl.prbsEnable_i = !dl.prbsEnable_i;
      #1;
      checks++;
      if ({dl.usrReady_o, dl.icReady_o, dl.ecReady_o} !== {m_usr_ready(), m_sc_ready(icq.size()), m_sc_ready(ecq.size())}) begin
        failures++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, {dl.usrReady_o, dl.icReady_o, dl.ecReady_o},
          {m_usr_ready(), m_sc_ready(icq.size()), m_sc_ready(ecq.size())});
      end
      tick();
      checks++;
      if ({dl.downlinkUserData_o, dl.downlinkIcData_o, dl.downlinkEcData_o, dl.fifoLevel_o, dl.idleCnt_o, dl.frameCnt_o}
          !== {m_data, m_ic, m_ec, 5'(q.size()), m_idle, m_frame}) begin
        failures++; $display("FAIL rnd_out[%0d] got %h/%b/%b/%0d/%0d/%0d exp %h/%b/%b/%0d/%0d/%0d", i,
          dl.downlinkUserData_o, dl.downlinkIcData_o, dl.downlinkEcData_o, dl.fifoLevel_o, dl.idleCnt_o, dl.frameCnt_o,
          m_data, m_ic, m_ec, q.size(), m_idle, m_frame);
      end
    end
    rst = 1'b0;
    dl.usrValid_i = 1'b0; dl.icValid_i = 1'b0; dl.ecValid_i = 1'b0; dl.prbsEnable_i = 1'b0;
  endtask

  initial begin
    dl.downlinkRdy_i = 1'b0;
    dl.usrData_i = '0;
    dl.usrValid_i = 1'b0;
    dl.icByte_i = '0;
    dl.icValid_i = 1'b0;
    dl.ecByte_i = '0;
    dl.ecValid_i = 1'b0;
    dl.prbsEnable_i = 1'b0;
    reseed();
    test_reset();
    test_latency();
    test_fill();
    test_ic();
    test_reset_mid();
    test_prbs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
